// File: rtl/fluxo_dados_param_pkg.sv
// Shared definitions for the memory-game datapath: playback sequencer states
// and the width helper used to size counters and timers.
package fluxo_dados_param_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ACESO   = 2'd1,
    APAGADO = 2'd2,
    FIM     = 2'd3
  } estado_exib_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fluxo_dados_param_if.sv
// Control/status bundle between the game control unit (master) and the
// datapath (slave).
interface fluxo_dados_param_if #(
  parameter int N_BOT = 4,
  parameter int AW    = 4
);
  logic [1:0]       modo;
  logic             registraModo;
  logic             zeraCL;
  logic             contaCL;
  logic             zeraC;
  logic             contaC;
  logic             zeraR;
  logic             registraR;
  logic             escreve;
  logic             botoes_fixo;
  logic [N_BOT-1:0] botoes;
  logic             zeraTimeout;
  logic             contaTimeout;
  logic             inicia_exibicao;
  logic             mostra_botoes;

  logic             fimRodada;
  logic             fimTotal;
  logic             fimC;
  logic             igual;
  logic             jogada_feita;
  logic             jogada_invalida;
  logic             fimTimeout;
  logic             exibindo;
  logic             fim_exibicao;
  logic [N_BOT-1:0] leds;
  logic             configTimeout_reg;
  logic [AW-1:0]    db_rodada;
  logic [AW-1:0]    db_contagem;
  logic [N_BOT-1:0] db_memoria;
  logic [N_BOT-1:0] db_jogada;

  modport master (
    output modo, registraModo, zeraCL, contaCL, zeraC, contaC, zeraR,
           registraR, escreve, botoes_fixo, botoes, zeraTimeout,
           contaTimeout, inicia_exibicao, mostra_botoes,
    input  fimRodada, fimTotal, fimC, igual, jogada_feita, jogada_invalida,
           fimTimeout, exibindo, fim_exibicao, leds, configTimeout_reg,
           db_rodada, db_contagem, db_memoria, db_jogada
  );

  modport slave (
    input  modo, registraModo, zeraCL, contaCL, zeraC, contaC, zeraR,
           registraR, escreve, botoes_fixo, botoes, zeraTimeout,
           contaTimeout, inicia_exibicao, mostra_botoes,
    output fimRodada, fimTotal, fimC, igual, jogada_feita, jogada_invalida,
           fimTimeout, exibindo, fim_exibicao, leds, configTimeout_reg,
           db_rodada, db_contagem, db_memoria, db_jogada
  );
endinterface

// File: rtl/fluxo_dados_param_sequenciador_exibicao.sv
// Autonomous playback: walks the stored sequence from address 0 up to the
// current round, lighting each item then leaving a dark gap.
//   state   | meaning
//   OCIOSO  | idle, waiting for inicia
//   ACESO   | item mem[ptr] lit for ACESO_M cycles
//   APAGADO | LEDs dark for APAGADO_M cycles, then next item or FIM
//   FIM     | one-cycle end-of-playback pulse
module fluxo_dados_param_sequenciador_exibicao
  import fluxo_dados_param_pkg::*;
#(
  parameter int AW        = 4,
  parameter int ACESO_M   = 2000,
  parameter int APAGADO_M = 500
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inicia,
  input  logic [AW-1:0] rodada,
  output logic [AW-1:0] addr,
  output logic          exibindo,
  output logic          fim_exibicao,
  output logic          led_en
);

  localparam int TW = largura((ACESO_M > APAGADO_M) ? ACESO_M : APAGADO_M);

  estado_exib_t  r_estado;
  logic [AW-1:0] r_ptr;
  logic [TW-1:0] r_timer;
  logic          r_exibindo;
  logic          r_fim;
  logic          r_led_en;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado   <= OCIOSO;
      r_ptr      <= '0;
      r_timer    <= '0;
      r_exibindo <= 1'b0;
      r_fim      <= 1'b0;
      r_led_en   <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (inicia) begin
            r_ptr      <= '0;
            r_timer    <= '0;
            r_estado   <= ACESO;
            r_exibindo <= 1'b1;
            r_led_en   <= 1'b1;
          end
        end
        ACESO: begin
          if (r_timer == TW'(ACESO_M - 1)) begin
            r_timer  <= '0;
            r_estado <= APAGADO;
            r_led_en <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        APAGADO: begin
          if (r_timer == TW'(APAGADO_M - 1)) begin
            // rodada is read live; the control unit holds it during playback
            if (r_ptr == rodada) begin
              r_estado <= FIM;
              r_fim    <= 1'b1;
            end else begin
              r_ptr    <= r_ptr + 1'b1;
              r_timer  <= '0;
              r_estado <= ACESO;
              r_led_en <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        FIM: begin
          r_estado   <= OCIOSO;
          r_fim      <= 1'b0;
          r_exibindo <= 1'b0;
        end
        default: begin
          r_estado   <= OCIOSO;
          r_fim      <= 1'b0;
          r_exibindo <= 1'b0;
          r_led_en   <= 1'b0;
        end
      endcase
    end
  end

  assign addr         = r_ptr;
  assign exibindo     = r_exibindo;
  assign fim_exibicao = r_fim;
  assign led_en       = r_led_en;

endmodule

// File: rtl/fluxo_dados_param.sv
// Memory-game datapath: round/play counters, sequence RAM, button register,
// edge and invalid-move detection, play timeout and LED drive.
module fluxo_dados_param
  import fluxo_dados_param_pkg::*;
#(
  parameter int N_BOT      = 4,
  parameter int DEPTH      = 16,
  parameter int AW         = largura(DEPTH),
  parameter int LIM_LONGO  = 16,
  parameter int LIM_CURTO  = 4,
  parameter int TIMEOUT_M  = 5000,
  parameter int ACESO_M    = 2000,
  parameter int APAGADO_M  = 500,
  parameter int VALOR_FIXO = 1
) (
  input  logic               clock,
  input  logic               reset,
  fluxo_dados_param_if.slave bus
);

  localparam int TW = largura(TIMEOUT_M);

  logic [1:0]       r_modo;
  logic [AW-1:0]    r_rodada;
  logic [AW-1:0]    r_contj;
  logic [N_BOT-1:0] r_jogada;
  logic             r_prev;
  logic [TW-1:0]    r_timeout;
  logic [N_BOT-1:0] r_mem [DEPTH];

  logic [AW-1:0]    w_addr;
  logic [AW-1:0]    w_ptr;
  logic [AW-1:0]    w_limite;
  logic [N_BOT-1:0] w_dado_wr;
  logic [N_BOT-1:0] w_leitura;
  logic             w_exibindo;
  logic             w_fim;
  logic             w_led_en;
  logic             w_borda;
  logic             w_multi;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_modo    <= '0;
      r_rodada  <= '0;
      r_contj   <= '0;
      r_jogada  <= '0;
      r_prev    <= 1'b0;
      r_timeout <= '0;
    end else begin
      if (bus.registraModo) r_modo <= bus.modo;

      if (bus.zeraCL)
        r_rodada <= '0;
      else if (bus.contaCL)
        r_rodada <= (r_rodada == AW'(DEPTH - 1)) ? '0 : r_rodada + 1'b1;

      if (bus.zeraC)
        r_contj <= '0;
      else if (bus.contaC)
        r_contj <= (r_contj == AW'(DEPTH - 1)) ? '0 : r_contj + 1'b1;

      if (bus.zeraR)
        r_jogada <= '0;
      else if (bus.registraR)
        r_jogada <= bus.botoes;

      r_prev <= |bus.botoes;

      // Saturates at the terminal value so fimTimeout stays asserted
      if (bus.zeraTimeout)
        r_timeout <= '0;
      else if (bus.contaTimeout && (r_timeout != TW'(TIMEOUT_M - 1)))
        r_timeout <= r_timeout + 1'b1;
    end
  end

  // RAM contents survive reset; the sequencer owns the address while playing
  always_ff @(posedge clock) begin
    if (bus.escreve && !w_exibindo)
      r_mem[r_contj] <= w_dado_wr;
  end

  fluxo_dados_param_sequenciador_exibicao #(
    .AW        (AW),
    .ACESO_M   (ACESO_M),
    .APAGADO_M (APAGADO_M)
  ) u_sequenciador_exibicao (
    .clock        (clock),
    .reset        (reset),
    .inicia       (bus.inicia_exibicao),
    .rodada       (r_rodada),
    .addr         (w_ptr),
    .exibindo     (w_exibindo),
    .fim_exibicao (w_fim),
    .led_en       (w_led_en)
  );

  assign w_dado_wr = bus.botoes_fixo ? N_BOT'(VALOR_FIXO) : bus.botoes;
  assign w_addr    = w_exibindo ? w_ptr : r_contj;
  assign w_leitura = r_mem[w_addr];
  assign w_limite  = r_modo[0] ? AW'(LIM_CURTO - 1) : AW'(LIM_LONGO - 1);

  // More than one button: clearing the lowest set bit leaves something
  assign w_borda = reset & (|bus.botoes) & ~r_prev;
  assign w_multi = ((bus.botoes & (bus.botoes - 1'b1)) != '0);

  assign bus.fimTotal          = (r_rodada == w_limite);
  assign bus.fimRodada         = (r_contj == r_rodada);
  assign bus.fimC              = (r_contj == AW'(DEPTH - 1));
  assign bus.igual             = (w_leitura == r_jogada);
  assign bus.jogada_feita      = w_borda;
  assign bus.jogada_invalida   = w_borda & w_multi;
  assign bus.fimTimeout        = (r_timeout == TW'(TIMEOUT_M - 1)) & r_modo[1];
  assign bus.exibindo          = w_exibindo;
  assign bus.fim_exibicao      = w_fim;
  assign bus.configTimeout_reg = r_modo[1];
  assign bus.db_rodada         = r_rodada;
  assign bus.db_contagem       = r_contj;
  assign bus.db_memoria        = w_leitura;
  assign bus.db_jogada         = r_jogada;

  always_comb begin
    bus.leds = '0;
    if (!reset)
      bus.leds = '0;
    else if (w_exibindo)
      bus.leds = w_led_en ? w_leitura : '0;
    else
      bus.leds = bus.botoes & {N_BOT{bus.mostra_botoes}};
  end

endmodule

// File: tb/tb_fluxo_dados_param.sv
// Directed self-checking bench for fluxo_dados_param with short timing
// constants so playback and timeout fit in a few dozen cycles.
module tb_fluxo_dados_param;

  localparam int N_BOT = 4;
  localparam int AW    = 4;

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  fluxo_dados_param_if #(.N_BOT(N_BOT), .AW(AW)) bus ();

  fluxo_dados_param #(
    .N_BOT      (N_BOT),
    .DEPTH      (16),
    .AW         (AW),
    .LIM_LONGO  (16),
    .LIM_CURTO  (4),
    .TIMEOUT_M  (8),
    .ACESO_M    (4),
    .APAGADO_M  (2),
    .VALOR_FIXO (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] pat [3];
  logic [3:0] exp_leds;

  initial begin
    pat[0] = 4'b0001;
    pat[1] = 4'b0010;
    pat[2] = 4'b1000;

    reset                = 1'b0;
    bus.modo             = 2'b00;
    bus.registraModo     = 1'b0;
    bus.zeraCL           = 1'b0;
    bus.contaCL          = 1'b0;
    bus.zeraC            = 1'b0;
    bus.contaC           = 1'b0;
    bus.zeraR            = 1'b0;
    bus.registraR        = 1'b0;
    bus.escreve          = 1'b0;
    bus.botoes_fixo      = 1'b0;
    bus.botoes           = '0;
    bus.zeraTimeout      = 1'b0;
    bus.contaTimeout     = 1'b0;
    bus.inicia_exibicao  = 1'b0;
    bus.mostra_botoes    = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_leds", bus.leds, 0);
    chk("rst_rodada", bus.db_rodada, 0);
    chk("rst_contagem", bus.db_contagem, 0);
    chk("rst_exibindo", bus.exibindo, 0);
    chk("rst_cfg_timeout", bus.configTimeout_reg, 0);
    chk("rst_fim_exib", bus.fim_exibicao, 0);
    chk("rst_jogada_feita", bus.jogada_feita, 0);
    reset = 1'b1;

    // short mode: limit at rodada=3
    bus.modo = 2'b01; bus.registraModo = 1'b1;
    tick();
    bus.registraModo = 1'b0;
    chk("short_cfg_timeout", bus.configTimeout_reg, 0);
    bus.contaCL = 1'b1;
    tick(); tick();
    chk("short_fimTotal_r2", bus.fimTotal, 0);
    tick();
    chk("short_rodada_r3", bus.db_rodada, 3);
    chk("short_fimTotal_r3", bus.fimTotal, 1);
    bus.contaCL = 1'b0;

    // long mode: limit at rodada=15, then wrap and clear priority
    bus.modo = 2'b00; bus.registraModo = 1'b1;
    tick();
    bus.registraModo = 1'b0;
    chk("long_fimTotal_r3", bus.fimTotal, 0);
    bus.contaCL = 1'b1;
    repeat (11) tick();
    chk("long_rodada_r14", bus.db_rodada, 14);
    chk("long_fimTotal_r14", bus.fimTotal, 0);
    tick();
    chk("long_fimTotal_r15", bus.fimTotal, 1);
    tick();
    chk("rodada_wrap", bus.db_rodada, 0);
    tick();
    chk("rodada_inc", bus.db_rodada, 1);
    bus.zeraCL = 1'b1;
    tick();
    chk("rodada_clear_prio", bus.db_rodada, 0);
    bus.zeraCL = 1'b0; bus.contaCL = 1'b0;

    // write / compare at contJ=0
    bus.botoes = 4'b0100; bus.escreve = 1'b1;
    tick();
    bus.escreve = 1'b0; bus.registraR = 1'b1;
    tick();
    bus.registraR = 1'b0;
    chk("wr_memoria", bus.db_memoria, 4'b0100);
    chk("wr_jogada", bus.db_jogada, 4'b0100);
    chk("wr_igual_1", bus.igual, 1);
    bus.botoes = 4'b0010; bus.registraR = 1'b1;
    tick();
    bus.registraR = 1'b0;
    chk("wr_igual_0", bus.igual, 0);
    bus.botoes_fixo = 1'b1; bus.escreve = 1'b1;
    tick();
    bus.botoes_fixo = 1'b0; bus.escreve = 1'b0;
    chk("wr_fixo", bus.db_memoria, 4'b0001);
    bus.zeraR = 1'b1; bus.registraR = 1'b1;
    tick();
    bus.zeraR = 1'b0; bus.registraR = 1'b0;
    chk("zeraR_prio", bus.db_jogada, 0);

    // load playback sequence into mem[0..2]
    bus.escreve = 1'b1; bus.contaC = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.botoes = pat[k];
      tick();
    end
    bus.escreve = 1'b0; bus.contaC = 1'b0; bus.botoes = '0;
    chk("contj_after_load", bus.db_contagem, 3);
    bus.zeraC = 1'b1; bus.zeraCL = 1'b1;
    tick();
    bus.zeraC = 1'b0; bus.zeraCL = 1'b0;
    bus.contaCL = 1'b1;
    tick(); tick();
    bus.contaCL = 1'b0;
    chk("fimRodada_0", bus.fimRodada, 0);
    bus.contaC = 1'b1;
    tick(); tick();
    bus.contaC = 1'b0;
    chk("fimRodada_1", bus.fimRodada, 1);

    // playback of three items, with write and restart attempts mid-way
    bus.inicia_exibicao = 1'b1;
    tick();
    bus.inicia_exibicao = 1'b0;
    for (int i = 0; i < 18; i++) begin
      exp_leds = ((i % 6) < 4) ? pat[i / 6] : 4'b0000;
      chk("play_leds", bus.leds, exp_leds);
      chk("play_exibindo", bus.exibindo, 1);
      chk("play_fim_early", bus.fim_exibicao, 0);
      if (i == 3) begin bus.escreve = 1'b1; bus.botoes = 4'b1111; end
      if (i == 6) begin bus.escreve = 1'b0; bus.botoes = 4'b0000; end
      if (i == 8) bus.inicia_exibicao = 1'b1;
      if (i == 9) bus.inicia_exibicao = 1'b0;
      tick();
    end
    chk("play_fim_pulse", bus.fim_exibicao, 1);
    chk("play_fim_leds", bus.leds, 0);
    chk("play_fim_exibindo", bus.exibindo, 1);
    tick();
    chk("play_after_fim", bus.fim_exibicao, 0);
    chk("play_after_exib", bus.exibindo, 0);
    chk("play_no_write", bus.db_memoria, 4'b1000);

    // LED echo outside playback
    bus.botoes = 4'b0101; bus.mostra_botoes = 1'b1;
    #1;
    chk("echo_on", bus.leds, 4'b0101);
    bus.mostra_botoes = 1'b0;
    #1;
    chk("echo_off", bus.leds, 0);
    bus.botoes = '0;

    // edge detection and invalid move
    tick();
    bus.botoes = 4'b0011;
    #1;
    chk("btn_feita", bus.jogada_feita, 1);
    chk("btn_invalida", bus.jogada_invalida, 1);
    tick();
    chk("btn_feita_held", bus.jogada_feita, 0);
    chk("btn_invalida_held", bus.jogada_invalida, 0);
    tick();
    chk("btn_feita_held2", bus.jogada_feita, 0);
    bus.botoes = '0;
    tick();
    bus.botoes = 4'b0100;
    #1;
    chk("btn_single_feita", bus.jogada_feita, 1);
    chk("btn_single_invalida", bus.jogada_invalida, 0);
    tick();
    bus.botoes = '0;

    // timeout disabled, then enabled
    bus.zeraTimeout = 1'b1;
    tick();
    bus.zeraTimeout = 1'b0; bus.contaTimeout = 1'b1;
    repeat (10) tick();
    chk("to_disabled", bus.fimTimeout, 0);
    bus.modo = 2'b10; bus.registraModo = 1'b1;
    tick();
    bus.registraModo = 1'b0;
    chk("to_cfg", bus.configTimeout_reg, 1);
    chk("to_enabled_held", bus.fimTimeout, 1);
    bus.zeraTimeout = 1'b1;
    tick();
    bus.zeraTimeout = 1'b0;
    chk("to_clear_prio", bus.fimTimeout, 0);
    repeat (6) tick();
    chk("to_count6", bus.fimTimeout, 0);
    tick();
    chk("to_count7", bus.fimTimeout, 1);
    bus.contaTimeout = 1'b0;

    // play counter end
    bus.zeraC = 1'b1;
    tick();
    bus.zeraC = 1'b0; bus.contaC = 1'b1;
    repeat (14) tick();
    chk("fimC_14", bus.fimC, 0);
    tick();
    chk("fimC_15", bus.fimC, 1);
    chk("contagem_15", bus.db_contagem, 15);
    tick();
    chk("contagem_wrap", bus.db_contagem, 0);
    bus.contaC = 1'b0;

    // reset during ACESO
    bus.inicia_exibicao = 1'b1;
    tick();
    bus.inicia_exibicao = 1'b0;
    tick();
    chk("midrst_pre_exib", bus.exibindo, 1);
    chk("midrst_pre_leds", bus.leds, 4'b0001);
    reset = 1'b0;
    tick();
    chk("midrst_leds", bus.leds, 0);
    chk("midrst_exibindo", bus.exibindo, 0);
    chk("midrst_fim", bus.fim_exibicao, 0);
    chk("midrst_cfg", bus.configTimeout_reg, 0);
    reset = 1'b1;
    repeat (8) tick();
    chk("midrst_no_fim_later", bus.fim_exibicao, 0);
    chk("midrst_exib_later", bus.exibindo, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fluxo_dados_param.md
Name: fluxo_dados_param

Overview:
- Parametrised datapath for the memory-sequence game: round and play counters, sequence RAM, button register and edge detection, timeout timer, and LED drive.
- Generalised over button count, memory depth and timing constants.
- New: an autonomous playback sequencer that replays the stored sequence on the LEDs without control-unit stepping, a multi-button (invalid move) detector, and a timeout that can be disabled.
- Sits under the game top, driven by the existing-style control FSM.

Parameters:
- N_BOT, 4, number of buttons/LEDs; RAM word width
- DEPTH, 16, RAM depth and maximum sequence length
- AW, $clog2(DEPTH), address/counter width
- LIM_LONGO, 16, rounds in long mode (≤ DEPTH)
- LIM_CURTO, 4, rounds in short mode (≤ LIM_LONGO)
- TIMEOUT_M, 5000, play timeout in cycles
- ACESO_M, 2000, cycles each playback item is lit
- APAGADO_M, 500, dark gap cycles between playback items
- VALOR_FIXO, 1, one-hot word written when botoes_fixo=1

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-low reset
- modo  in  2  [0]=short mode, [1]=timeout enable
- registraModo  in  1  latch modo
- zeraCL / contaCL  in  1/1  round counter clear / increment
- zeraC / contaC  in  1/1  play counter clear / increment
- zeraR / registraR  in  1/1  button register clear / load
- escreve  in  1  RAM write at play-counter address
- botoes_fixo  in  1  write VALOR_FIXO instead of botoes
- botoes  in  N_BOT  raw buttons, already synchronised
- zeraTimeout / contaTimeout  in  1/1  timeout timer control
- inicia_exibicao  in  1  start playback (pulse)
- mostra_botoes  in  1  echo botoes on LEDs when not playing
- fimRodada, fimTotal, fimC, igual  out  1  comparisons
- jogada_feita  out  1  one-cycle pulse
- jogada_invalida  out  1  one-cycle pulse
- fimTimeout  out  1  timeout reached
- exibindo  out  1  playback in progress
- fim_exibicao  out  1  one-cycle pulse at end of playback
- leds  out  N_BOT  LED drive
- configTimeout_reg  out  1  latched modo[1]
- db_rodada, db_contagem  out  AW  round counter / play counter
- db_memoria, db_jogada  out  N_BOT  RAM read data / button register

Behaviour:
- Reset (reset=0 at edge): all counters and timers to 0, mode registers to 0 (long mode, timeout off), button register to 0, edge-detector history to 0, sequencer to OCIOSO.
- Reset outputs: leds=0, exibindo=0, pulses=0.
- RAM contents are not reset.
- All clears are synchronous and take priority over count or load in the same cycle.
- Round counter (rodada) and play counter (contJ): AW bits, wrap DEPTH-1→0. fimC=(contJ==DEPTH-1).
- Comparisons (combinational):
  - limite = LIM_CURTO-1 if regModo[0]=1, else LIM_LONGO-1.
  - fimTotal=(rodada==limite).
  - fimRodada=(contJ==rodada).
- RAM: synchronous write, combinational read.
  - Address = ptr while exibindo=1, else contJ.
  - Write data = VALOR_FIXO if botoes_fixo=1, else botoes.
  - Writes are suppressed while exibindo=1.
  - igual=(mem[addr]==button register).
- Edge detector: prev<=|botoes each cycle. jogada_feita=|botoes & ~prev.
  - If buttons are held through reset release, jogada_feita pulses on the first cycle after reset.
- jogada_invalida: pulses with jogada_feita when popcount(botoes)>1.
- Timeout timer: counts 0..TIMEOUT_M-1 and holds at TIMEOUT_M-1.
  - fimTimeout = (count==TIMEOUT_M-1) & configTimeout_reg.
- Playback sequencer FSM:
  - OCIOSO: on inicia_exibicao, ptr←0, timer←0, go to ACESO. inicia_exibicao is ignored in any other state.
  - ACESO: leds=mem[ptr]. When timer==ACESO_M-1, timer←0 and go to APAGADO.
  - APAGADO: leds=0. When timer==APAGADO_M-1: if ptr==rodada go to FIM, else ptr←ptr+1, timer←0, go to ACESO.
  - FIM: fim_exibicao=1 for one cycle, then go to OCIOSO.
  - exibindo=1 in ACESO, APAGADO and FIM.
  - Total playback latency = (rodada+1)·(ACESO_M+APAGADO_M)+1 cycles from the start edge to fim_exibicao.
  - rodada is sampled live; the control unit must not change it during playback.
- LEDs outside playback: leds = botoes & {N_BOT{mostra_botoes}}.
- Reset mid-playback returns to OCIOSO immediately with leds=0 and no fim_exibicao pulse.

Decomposition:
- Shared package: sequencer state encoding (OCIOSO, ACESO, APAGADO, FIM; 2 bits) and the AW derivation.
- Sub-module: sequenciador_exibicao, owning the FSM, ptr and its own timer. It exports addr, exibindo, fim_exibicao and the LED enable.
- Counters, RAM and comparators stay inline or reuse the existing counter and comparator blocks.

Test Plan:
- Reset: hold reset=0 for 2 cycles with botoes=0 → leds=0, db_rodada=0, db_contagem=0, exibindo=0, configTimeout_reg=0.
- Mode and round limit: registraModo with modo=2'b01, contaCL pulsed 3× → fimTotal=1 at rodada=3. The same with modo=2'b00 → fimTotal=0 until rodada=15.
- Write/compare: contJ=0, botoes=4'b0100, escreve → mem[0]=4'b0100. registraR with 4'b0100 → igual=1. With 4'b0010 → igual=0. botoes_fixo=1 → stored 4'b0001.
- Playback: mem[0..2]={0001,0010,1000}, rodada=2, ACESO_M=4, APAGADO_M=2 (bench override), inicia_exibicao → LED pattern 0001×4, 0×2, 0010×4, 0×2, 1000×4, 0×2 → fim_exibicao at cycle 19; escreve during playback leaves RAM unchanged.
- Buttons: botoes 0→4'b0011 → jogada_feita=1 and jogada_invalida=1 for exactly one cycle. Holding the buttons produces no further pulse.
- Timeout: TIMEOUT_M=8 override, contaTimeout held. With modo[1]=0 → fimTimeout stays 0. With modo[1]=1 → fimTimeout=1 from the 8th counted cycle on. zeraTimeout together with contaTimeout → count returns to 0.
- Reset mid-playback: reset=0 during ACESO → next cycle leds=0, exibindo=0, no fim_exibicao pulse.
